// File: rtl/vc_input_buffer.sv
// vc_input_buffer: NUM_VC circular FIFOs sharing one storage array, with per-VC status and a one-cycle credit return.
// Define VC_INPUT_BUFFER_ERR_EN to build the sticky overflow/underflow flags; otherwise both read 0.
module vc_input_buffer #(
  parameter int FLIT_WIDTH = 128,
  parameter int NUM_VC     = 4,
  parameter int DEPTH      = 16,
  parameter int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [VC_W-1:0]             in_vc,
  input  logic [FLIT_WIDTH-1:0]       in_flit,
  input  logic [VC_W-1:0]             out_vc,
  input  logic                        out_pop,
  output logic [FLIT_WIDTH-1:0]       out_flit,
  output logic [NUM_VC-1:0]           vc_empty,
  output logic [NUM_VC-1:0]           vc_full,
  output logic [NUM_VC*(PTR_W+1)-1:0] vc_occ,
  output logic                        credit_valid,
  output logic [VC_W-1:0]             credit_vc,
  output logic                        err_overflow,
  output logic                        err_underflow
);

  localparam int                OCC_W    = PTR_W + 1;
  localparam logic [VC_W:0]     NUM_VC_L = (VC_W + 1)'(NUM_VC);
  localparam logic [OCC_W-1:0]  DEPTH_L  = OCC_W'(DEPTH);

  logic [FLIT_WIDTH-1:0] mem_q [NUM_VC*DEPTH];

  logic [PTR_W-1:0] wptr_q [NUM_VC];
  logic [PTR_W-1:0] wptr_d [NUM_VC];
  logic [PTR_W-1:0] rptr_q [NUM_VC];
  logic [PTR_W-1:0] rptr_d [NUM_VC];
  logic [OCC_W-1:0] occ_q  [NUM_VC];
  logic [OCC_W-1:0] occ_d  [NUM_VC];

  logic             credit_valid_q, credit_valid_d;
  logic [VC_W-1:0]  credit_vc_q, credit_vc_d;

  logic                  in_vc_ok, out_vc_ok;
  logic                  push_ok, pop_ok;
  logic [NUM_VC-1:0]     push_vec, pop_vec;
  logic [VC_W+PTR_W-1:0] wr_addr, rd_addr;

  // Storage slot for VC k, pointer p is k*DEPTH+p; DEPTH is a power of two so this is a concatenation.
  assign in_vc_ok  = {1'b0, in_vc}  < NUM_VC_L;
  assign out_vc_ok = {1'b0, out_vc} < NUM_VC_L;
  assign wr_addr   = {in_vc, wptr_q[in_vc]};
  assign rd_addr   = {out_vc, rptr_q[out_vc]};
  assign out_flit  = mem_q[rd_addr];

  for (genvar k = 0; k < NUM_VC; k++) begin : g_status
    assign vc_empty[k]               = (occ_q[k] == '0);
    assign vc_full[k]                = (occ_q[k] == DEPTH_L);
    assign vc_occ[k*OCC_W +: OCC_W]  = occ_q[k];
  end

  // Full/empty come from registered occupancy, so a same-cycle pop never makes room for a push
  // and a same-cycle push never feeds a pop.
  assign push_ok = in_valid & in_vc_ok  & ~vc_full[in_vc];
  assign pop_ok  = out_pop  & out_vc_ok & ~vc_empty[out_vc];

  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    if (push_ok) push_vec[in_vc] = 1'b1;
    if (pop_ok)  pop_vec[out_vc] = 1'b1;
    for (int k = 0; k < NUM_VC; k++) begin
      wptr_d[k] = wptr_q[k] + PTR_W'(push_vec[k]);
      rptr_d[k] = rptr_q[k] + PTR_W'(pop_vec[k]);
      occ_d[k]  = occ_q[k] + OCC_W'(push_vec[k]) - OCC_W'(pop_vec[k]);
    end
    credit_valid_d = pop_ok;
    credit_vc_d    = pop_ok ? out_vc : credit_vc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_VC; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        occ_q[k]  <= '0;
      end
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      occ_q          <= occ_d;
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
    end
  end

  // Flit storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_addr] <= in_flit;
  end

  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;

`ifdef VC_INPUT_BUFFER_ERR_EN
  logic err_overflow_q, err_overflow_d;
  logic err_underflow_q, err_underflow_d;

  always_comb begin
    err_overflow_d  = err_overflow_q  | (in_valid & ~push_ok);
    err_underflow_d = err_underflow_q | (out_pop  & ~pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: per-VC queue model checked every cycle, plus directed scenarios with literal expectations.
module tb_vc_input_buffer;
  localparam int FW    = 128;
  localparam int NV    = 4;
  localparam int DEPTH = 16;
  localparam int VW    = 2;
  localparam int OW    = 5;

`ifdef VC_INPUT_BUFFER_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [VW-1:0]    in_vc;
  logic [FW-1:0]    in_flit;
  logic [VW-1:0]    out_vc;
  logic             out_pop;
  logic [FW-1:0]    out_flit;
  logic [NV-1:0]    vc_empty;
  logic [NV-1:0]    vc_full;
  logic [NV*OW-1:0] vc_occ;
  logic             credit_valid;
  logic [VW-1:0]    credit_vc;
  logic             err_overflow;
  logic             err_underflow;

  vc_input_buffer #(.FLIT_WIDTH(FW), .NUM_VC(NV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .out_vc(out_vc), .out_pop(out_pop), .out_flit(out_flit),
    .vc_empty(vc_empty), .vc_full(vc_full), .vc_occ(vc_occ),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per VC plus the credit and sticky error state.
  logic [FW-1:0] mq [NV][$];
  bit            m_cv;
  logic [VW-1:0] m_cvc;
  bit            m_ovf, m_unf;
  bit            m_push, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) mq[v].delete();
      m_cv  = 1'b0;
      m_cvc = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_push = in_valid && (mq[in_vc].size() < DEPTH);
      m_pop  = out_pop  && (mq[out_vc].size() > 0);
      if (in_valid && !m_push) m_ovf = 1'b1;
      if (out_pop && !m_pop)   m_unf = 1'b1;
      if (m_pop)  void'(mq[out_vc].pop_front());
      if (m_push) mq[in_vc].push_back(in_flit);
      m_cv = m_pop;
      if (m_pop) m_cvc = out_vc;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      for (int v = 0; v < NV; v++) begin
        chk($sformatf("occ[%0d]", v), FW'(vc_occ[v*OW +: OW]), FW'(mq[v].size()));
        chk($sformatf("empty[%0d]", v), FW'(vc_empty[v]), FW'(mq[v].size() == 0));
        chk($sformatf("full[%0d]", v), FW'(vc_full[v]), FW'(mq[v].size() == DEPTH));
      end
      chk("credit_valid", FW'(credit_valid), FW'(m_cv));
      if (m_cv) chk("credit_vc", FW'(credit_vc), FW'(m_cvc));
      chk("err_overflow", FW'(err_overflow), FW'(m_ovf & ERR_ON));
      chk("err_underflow", FW'(err_underflow), FW'(m_unf & ERR_ON));
      if (mq[out_vc].size() > 0) chk("out_flit", out_flit, mq[out_vc][0]);
    end
  end

  task automatic set_in(input logic iv, input logic [VW-1:0] ivc, input logic [FW-1:0] fl,
                        input logic [VW-1:0] ovc, input logic op);
    in_valid = iv;
    in_vc    = ivc;
    in_flit  = fl;
    out_vc   = ovc;
    out_pop  = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] occ_of(input int v);
    return vc_occ[v*OW +: OW];
  endfunction

  function automatic logic [FW-1:0] rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [FW-1:0] f_tmp;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", FW'(vc_empty), FW'(4'b1111));
    chk("rst_occ", FW'(vc_occ), FW'(0));
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Four flits into VC2, drained in order with one credit per pop
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'd2, FW'(8'hA0 + i), 2'd0, 1'b0);
      tick();
    end
    set_in(1'b0, '0, '0, 2'd2, 1'b0);
    chk("t1_occ2", FW'(occ_of(2)), FW'(4));
    chk("t1_empty", FW'(vc_empty), FW'(4'b1011));
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, '0, '0, 2'd2, 1'b1);
      #1;
      chk("t1_head", out_flit, FW'(8'hA0 + i));
      tick();
      chk("t1_cv", FW'(credit_valid), FW'(1));
      chk("t1_cvc", FW'(credit_vc), FW'(2));
    end
    set_in(1'b0, '0, '0, '0, 1'b0);
    tick();
    chk("t1_cv_idle", FW'(credit_valid), FW'(0));

    // Fill VC1, then a 17th push alongside a pop is dropped
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 2'd1, FW'(16'h1100 + i), 2'd0, 1'b0);
      tick();
    end
    chk("t2_full", FW'(vc_full), FW'(4'b0010));
    chk("t2_occ1", FW'(occ_of(1)), FW'(16));
    set_in(1'b1, 2'd1, FW'(16'h11FF), 2'd1, 1'b1);
    tick();
    set_in(1'b0, '0, '0, 2'd1, 1'b0);
    #1;
    chk("t2_occ1_after", FW'(occ_of(1)), FW'(15));
    chk("t2_ovf", FW'(err_overflow), FW'(ERR_ON));
    chk("t2_head", out_flit, FW'(16'h1101));

    // VC0/VC3 interleave across pointer wrap
    for (int i = 0; i < 40; i++) begin
      f_tmp = rnd_flit();
      if (i % 2 == 0) set_in(1'b1, 2'd0, f_tmp, 2'd3, i > 0);
      else            set_in(1'b1, 2'd3, f_tmp, 2'd0, 1'b1);
      tick();
    end
    set_in(1'b0, '0, '0, '0, 1'b0);
    tick();
    chk("t3_unf", FW'(err_underflow), FW'(0));

    // Push to empty VC0 with a same-cycle pop: the pop is rejected
    set_in(1'b1, 2'd0, FW'(128'hC0FFEE), 2'd0, 1'b1);
    tick();
    set_in(1'b0, '0, '0, 2'd0, 1'b0);
    #1;
    chk("t4_occ0", FW'(occ_of(0)), FW'(1));
    chk("t4_unf", FW'(err_underflow), FW'(ERR_ON));
    chk("t4_head", out_flit, FW'(128'hC0FFEE));
    chk("t4_cv", FW'(credit_valid), FW'(0));

    // Bring VC1 down to 8, then steady push+pop
    for (int i = 0; i < 7; i++) begin
      set_in(1'b0, '0, '0, 2'd1, 1'b1);
      tick();
    end
    chk("t5_occ1_start", FW'(occ_of(1)), FW'(8));
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 2'd1, rnd_flit(), 2'd1, 1'b1);
      tick();
      chk("t5_occ1", FW'(occ_of(1)), FW'(8));
      chk("t5_cv", FW'(credit_valid), FW'(1));
      chk("t5_cvc", FW'(credit_vc), FW'(1));
    end

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(0, 9) < 7, VW'($urandom_range(0, NV - 1)), rnd_flit(),
             VW'($urandom_range(0, NV - 1)), $urandom_range(0, 1) == 1);
      tick();
    end

    // Reset mid-cycle with VC3 holding flits and a credit pending
    set_in(1'b0, '0, '0, '0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 2'd3, FW'(8'hD0 + i), 2'd3, 1'b0);
      tick();
    end
    chk("t6_occ3", FW'(occ_of(3)), FW'(5));
    set_in(1'b0, '0, '0, 2'd3, 1'b1);
    tick();
    chk("t6_cv_pending", FW'(credit_valid), FW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_empty", FW'(vc_empty), FW'(4'b1111));
    chk("t6_rst_full", FW'(vc_full), FW'(0));
    chk("t6_rst_occ", FW'(vc_occ), FW'(0));
    chk("t6_rst_cv", FW'(credit_valid), FW'(0));
    chk("t6_rst_cvc", FW'(credit_vc), FW'(0));
    chk("t6_rst_ovf", FW'(err_overflow), FW'(0));
    chk("t6_rst_unf", FW'(err_underflow), FW'(0));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_credit", FW'(credit_valid), FW'(0));
      chk("t6_empty3", FW'(vc_empty[3]), FW'(1));
    end
    set_in(1'b0, '0, '0, '0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
